// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack handshake
// and buffers {pc, inst} in a small circular FIFO for the decode stage.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [5:0]  opcode
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       drain_addr_q, drain_addr_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       pc_mem_q   [DEPTH];
  logic [31:0]       inst_mem_q [DEPTH];

  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  occ_after_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    redirect      = jump | branch_taken;
    redirect_pc   = jump ? {jump_target[31:2], 2'b00} : {branch_target[31:2], 2'b00};
    inst_valid    = (count_q != '0) && !redirect;
    pop           = inst_valid && inst_ready;
    push          = (state_q == BUSY) && imem_ack && !redirect;
    occ_after_pop = count_q - CNT_W'(pop);
    count_d       = occ_after_pop + CNT_W'(push);
    wptr_d        = push ? next_ptr(wptr_q) : wptr_q;
    rptr_d        = pop ? next_ptr(rptr_q) : rptr_q;
    fetch_pc_d    = push ? fetch_pc_q + 32'd4 : fetch_pc_q;
    drain_addr_d  = drain_addr_q;
    state_d       = state_q;

    if (redirect) begin
      count_d    = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      fetch_pc_d = redirect_pc;
    end

    case (state_q)
      IDLE: begin
        if (!redirect && occ_after_pop < FULL_CNT) state_d = BUSY;
      end
      BUSY: begin
        if (redirect) begin
          // The request already on the bus must complete; remember its address.
          if (imem_ack) begin
            state_d = IDLE;
          end else begin
            state_d      = DRAIN;
            drain_addr_d = fetch_pc_q;
          end
        end else if (imem_ack && count_d >= FULL_CNT) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    imem_req  = (state_q != IDLE);
    imem_addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
    inst      = inst_mem_q[rptr_q];
    inst_pc   = pc_mem_q[rptr_q];
    opcode    = inst[31:26];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wptr_q]   <= fetch_pc_q;
      inst_mem_q[wptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: sequential fetch, backpressure, redirects,
// misaligned jump with PC wrap and asynchronous reset.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [5:0]  opcode;

  int checks;
  int failures;

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .opcode(opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content is a fixed function of the address; address 4 gives 32'h8C01_0004.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {6'b100011 ^ a[9:4], 10'h001, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    imem_ack = 1'b1;
    inst_ready = 1'b1;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    jump = 1'b0;
    jump_target = 32'h0;

    // Sequential fetch with zero-wait memory
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk($sformatf("seq_req%0d", i), {31'b0, imem_req}, 32'd1);
      chk($sformatf("seq_addr%0d", i), imem_addr, 32'(4 * i));
      if (i > 0) begin
        chk($sformatf("seq_valid%0d", i), {31'b0, inst_valid}, 32'd1);
        chk($sformatf("seq_pc%0d", i), inst_pc, 32'(4 * (i - 1)));
        chk($sformatf("seq_inst%0d", i), inst, mem_word(32'(4 * (i - 1))));
      end
      if (i == 2) chk("seq_opcode", {26'b0, opcode}, {26'b0, 6'b100011});
    end

    // Backpressure: decode stalls for 5 cycles
    inst_ready = 1'b0;
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      tick();
      #1;
      if (c >= 3) begin
        chk($sformatf("bp_req_c%0d", c), {31'b0, imem_req}, 32'd0);
        chk($sformatf("bp_valid_c%0d", c), {31'b0, inst_valid}, 32'd1);
        chk($sformatf("bp_pc_c%0d", c), inst_pc, 32'h0);
      end
    end
    tick();
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp_rel_valid%0d", k), {31'b0, inst_valid}, 32'd1);
      chk($sformatf("bp_rel_pc%0d", k), inst_pc, 32'(4 * k));
      tick();
    end

    // Branch while a slow request to address 8 is outstanding
    do_reset();
    tick();
    tick();
    tick();
    imem_ack = 1'b0;
    #1;
    chk("br_addr8", imem_addr, 32'h8);
    tick();
    branch_taken = 1'b1;
    branch_target = 32'h100;
    #1;
    chk("br_valid_redirect", {31'b0, inst_valid}, 32'd0);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("drain_req", {31'b0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'h8);
    tick();
    imem_ack = 1'b1;
    #1;
    chk("drain_addr_ack", imem_addr, 32'h8);
    tick();
    #1;
    chk("drain_dropped_valid", {31'b0, inst_valid}, 32'd0);
    chk("drain_idle_req", {31'b0, imem_req}, 32'd0);
    tick();
    #1;
    chk("br_next_addr", imem_addr, 32'h100);
    tick();
    #1;
    chk("br_first_valid", {31'b0, inst_valid}, 32'd1);
    chk("br_first_pc", inst_pc, 32'h100);
    chk("br_first_inst", inst, mem_word(32'h100));

    // Jump and branch together with an ack: jump wins, acked word dropped
    jump = 1'b1;
    jump_target = 32'h40;
    branch_taken = 1'b1;
    branch_target = 32'h80;
    #1;
    chk("sim_valid_redirect", {31'b0, inst_valid}, 32'd0);
    tick();
    jump = 1'b0;
    branch_taken = 1'b0;
    #1;
    chk("sim_flushed", {31'b0, inst_valid}, 32'd0);
    chk("sim_idle", {31'b0, imem_req}, 32'd0);
    tick();
    #1;
    chk("sim_next_addr", imem_addr, 32'h40);
    tick();
    #1;
    chk("sim_first_pc", inst_pc, 32'h40);
    chk("sim_first_valid", {31'b0, inst_valid}, 32'd1);

    // Misaligned jump target and PC wrap-around
    jump = 1'b1;
    jump_target = 32'hFFFF_FFFF;
    tick();
    jump = 1'b0;
    tick();
    #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    #1;
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
    tick();
    #1;
    chk("wrap_pc1", inst_pc, 32'h0);
    chk("wrap_valid", {31'b0, inst_valid}, 32'd1);

    // Asynchronous reset while BUSY, asserted between edges
    #2;
    chk("ar_pre_req", {31'b0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_req", {31'b0, imem_req}, 32'd0);
    chk("ar_valid", {31'b0, inst_valid}, 32'd0);
    chk("ar_addr", imem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    chk("ar_restart_req", {31'b0, imem_req}, 32'd1);
    chk("ar_restart_addr", imem_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage for the 32-bit MIPS CPU. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers fetched words in a small FIFO. It delivers {pc, instruction} to the decode stage with a valid/ready handshake and drives the 6-bit opcode consumed by `control_unit`. Branch and jump redirects from execute flush the FIFO and discard any in-flight word.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: number of FIFO entries, at least 2.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `imem_req`, output, 1: read request, held until acked.
- `imem_addr`, output, 32: word address (bits [1:0]=0), stable while `imem_req` is high.
- `imem_ack`, input, 1: memory accepts the request; `imem_rdata` is valid in the same cycle.
- `imem_rdata`, input, 32: fetched instruction word.
- `branch_taken`, input, 1: taken branch redirect, one-cycle pulse.
- `branch_target`, input, 32: branch destination.
- `jump`, input, 1: jump redirect, one-cycle pulse.
- `jump_target`, input, 32: jump destination.
- `inst_valid`, output, 1: FIFO head is valid.
- `inst_ready`, input, 1: decode accepts the head.
- `inst`, output, 32: head instruction.
- `inst_pc`, output, 32: PC of the head instruction.
- `opcode`, output, 6: `inst[31:26]`, feeds `control_unit`.

## Operation
- **State machine:** IDLE, BUSY, DRAIN.
  - IDLE: `imem_req`=0. Go to BUSY next cycle if occupancy after this cycle's pop is below DEPTH.
  - BUSY: `imem_req`=1 and `imem_addr`=`fetch_pc`.
    - On `imem_ack`: push {`fetch_pc`, `imem_rdata`} and set `fetch_pc` += 4.
    - After the push, stay in BUSY if occupancy (counting the same-cycle pop) is below DEPTH; otherwise go to IDLE.
  - DRAIN: `imem_req`=1 and the old address is held. On `imem_ack` the data is dropped and the state goes to IDLE.
- **Redirect:** triggered by `jump` or `branch_taken`. If both are asserted, `jump` wins.
  - Target is `{target[31:2], 2'b00}`.
  - In the redirect cycle:
    - The FIFO is flushed.
    - `fetch_pc` is loaded with the target.
    - `inst_valid` is forced to 0, so no pop occurs that cycle.
    - Any `imem_ack` in that cycle is discarded.
  - State after a redirect:
    - BUSY without ack goes to DRAIN.
    - BUSY with ack goes to IDLE.
    - IDLE stays IDLE.
    - DRAIN stays DRAIN; if `imem_ack` arrives in the same cycle it goes to IDLE.
- **Second redirect during DRAIN:** the target is overwritten and the state stays in DRAIN.
- **FIFO:**
  - Circular buffer with DEPTH entries; pointers wrap modulo DEPTH.
  - Push and pop may occur in the same cycle when full; net occupancy is unchanged.
  - No push when full: the state machine guarantees this. Overflow is a verification assertion.
- **Arithmetic:** PC increment is modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0.
- **Outputs:**
  - `inst`, `inst_pc` and `opcode` come from the FIFO head combinationally.
  - They are don't-care when `inst_valid`=0.
  - `opcode`=`inst[31:26]` always.

## Timing
- **Reset values** (asynchronous, applied while `rst_n`=0):
  - State=IDLE, `fetch_pc`=RESET_PC.
  - FIFO empty, so `inst_valid`=0.
  - `imem_req`=0, `imem_addr`=RESET_PC.
- **Reset mid-transaction:** the outstanding request is abandoned and `imem_req` drops immediately. The memory side must tolerate this.
- **After reset release:** `imem_req` rises at the first clock edge after `rst_n` rises.
- **Fetch latency:** the word acked in cycle N appears with `inst_valid`=1 in cycle N+1.
- **Throughput:** with zero-wait memory (`imem_ack` tied to 1) and `inst_ready`=1, sustains one instruction per cycle.
- **Redirect latency:**
  - Redirect in cycle R with no outstanding request: `imem_addr`=target in cycle R+2 (IDLE→BUSY).
  - First instruction at the target appears no earlier than R+3.
- **Handshake rules:**
  - `inst_valid`, once asserted, stays high with the same head until accepted or a redirect occurs.
  - `imem_req`/`imem_addr` stay constant until ack or reset.

## Test plan
- **Reset then sequential fetch:** RESET_PC=0, `imem_ack`=1, `imem_rdata`=address-derived, `inst_ready`=1.
  - Required: `imem_addr` sequence 0,4,8,C on consecutive cycles.
  - Required: `inst_pc` 0,4,8,C one cycle later.
  - Required: `opcode` matches `rdata[31:26]`, e.g. 6'b100011 for word 32'h8C01_0004.
- **Backpressure:** `inst_ready`=0 for 5 cycles.
  - Required: FIFO fills to 2 and `imem_req` drops.
  - Required: the head stays at PC 0 with `inst_valid`=1.
  - Required: after release, no instruction is lost or duplicated.
- **Branch during wait-state:** `imem_ack` delayed 3 cycles, `branch_taken`=1 with target 32'h100 while BUSY at addr 8.
  - Required: DRAIN holds addr 8 until ack, the word is discarded.
  - Required: the next request is to 32'h100 and the first delivered `inst_pc`=32'h100.
- **Simultaneous events:** `jump` (target 32'h40) and `branch_taken` (target 32'h80) asserted in the same cycle as `imem_ack`.
  - Required: the acked data is dropped.
  - Required: next fetch is 32'h40.
  - Required: `inst_valid`=0 in the redirect cycle.
- **Misaligned target and wrap:** jump to 32'hFFFF_FFFF.
  - Required: fetches 32'hFFFF_FFFC then 32'h0000_0000.
- **Asynchronous reset mid-BUSY:** `rst_n` low between clock edges.
  - Required: `imem_req`=0 and `inst_valid`=0 immediately.
  - Required: after release, fetch restarts at RESET_PC.
